// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter that owns the select lines of a 4:1 mux (A, B, C, D).
//   One requester holds the grant at a time. A burst is capped at BURST_MAX
//   cycles while others wait. A one-cycle gap separates consecutive owners.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req[3:0]   : level requests, bit0 = A .. bit3 = D
//   gnt[3:0]   : registered one-hot grant, zero when there is no owner
//   sel1, sel2 : registered mux selects, {sel1,sel2} = owner index
//   busy       : high while any grant bit is high
//   burst_cnt  : cycles the current owner has held the grant, 0 when idle
module mux4_rr_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic             sel1,
  output logic             sel2,
  output logic             busy,
  output logic [CNT_W-1:0] burst_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;

  logic [1:0]         pick;
  logic [3:0]         pick_onehot;
  logic               at_max;
  logic               others_waiting;
  logic               owner_req;

  // First set request searching from ptr upward (mod 4). The loop runs from
  // the farthest offset to the nearest so the nearest hit is assigned last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick = rr_pick(req, ptr_q);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick == 2'(gi));
    end
  endgenerate

  assign at_max         = (cnt_q == CNT_W'(BURST_MAX));
  assign others_waiting = |(req & ~gnt_q);
  assign owner_req      = req[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    case (state_q)
      // IDLE and GAP arbitrate identically; GAP only differs in that it
      // never lingers (it falls back to IDLE when nothing is requested).
      ST_IDLE, ST_GAP: begin
        gnt_d = 4'b0000;
        cnt_d = '0;
        if (|req) begin
          state_d = ST_GRANT;
          owner_d = pick;
          gnt_d   = pick_onehot;
          sel_d   = pick;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A drop and a burst expiry on the same edge collapse into one gap.
        if (!owner_req || (at_max && others_waiting)) begin
          state_d = ST_GAP;
          gnt_d   = 4'b0000;
          cnt_d   = '0;
          ptr_d   = owner_q + 2'd1;
        end else if (at_max) begin
          // Nobody else wants the mux: start a fresh burst without a gap.
          cnt_d = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel1      = sel_q[1];
  assign sel2      = sel_q[0];
  assign busy      = |gnt_q;
  assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter: directed scenarios plus a randomized run,
// each cycle checked against a behavioural model of ownership and rotation.
module tb_mux4_rr_arbiter;

  localparam int BURST_MAX = 4;
  localparam int CNT_W     = 3;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic             sel1;
  logic             sel2;
  logic             busy;
  logic [CNT_W-1:0] burst_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural model: who owns the mux (-1 = nobody), where the next search
  // starts, how long the owner has held it, and the last select value.
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;

  logic [3:0]       exp_gnt;
  logic [1:0]       exp_sel;
  logic             exp_busy;
  logic [CNT_W-1:0] exp_cnt;

  mux4_rr_arbiter #(.BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .sel1      (sel1),
    .sel2      (sel2),
    .busy      (busy),
    .burst_cnt (burst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_sel   = 0;
  endtask

  // One clock of the arbitration rules. A cycle without an owner (idle or the
  // turnaround gap) grants whoever is first from m_ptr; an owner keeps the mux
  // until it lets go or its burst is spent while someone else is waiting.
  task automatic model_step(input logic [3:0] r);
    int others;
    if (m_owner >= 0) begin
      others = int'(r) & ~(1 << m_owner);
      if (!r[m_owner] || (m_cnt == BURST_MAX && others != 0)) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_cnt   = 0;
      end else begin
        m_cnt = (m_cnt == BURST_MAX) ? 1 : m_cnt + 1;
      end
    end else if (r != 4'b0000) begin
      for (int i = 3; i >= 0; i--)
        if (r[(m_ptr + i) % 4]) m_owner = (m_ptr + i) % 4;
      m_sel = m_owner;
      m_cnt = 1;
    end
    exp_gnt  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    exp_sel  = 2'(m_sel);
    exp_busy = (m_owner >= 0);
    exp_cnt  = CNT_W'(m_cnt);
  endtask

  // Drive one request vector for one clock, advance the model, settle.
  task automatic tick(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    cyc++;
    $display("cyc=%0d req=%b gnt=%b sel=%b%b busy=%b cnt=%0d", cyc, r, gnt, sel1, sel2, busy, burst_cnt);
  endtask

  task automatic apply_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({gnt, sel1, sel2, busy, burst_cnt} !== {4'b0000, 2'b00, 1'b0, CNT_W'(0)}) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b sel=%b%b busy=%b cnt=%0d want all zero", gnt, sel1, sel2, busy, burst_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Build up a grant for A, then pull reset between edges.
    tick(4'b1111);
    tick(4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, sel1, sel2, busy, burst_cnt} !== {4'b0000, 2'b00, 1'b0, CNT_W'(0)}) begin
      errors++;
      $display("FAIL reset_mid_grant: got gnt=%b sel=%b%b busy=%b cnt=%0d want all zero", gnt, sel1, sel2, busy, burst_cnt);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(4'b1111);
    checks++;
    if (gnt !== 4'b0001 || {sel1, sel2} !== 2'b00 || burst_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL reset_first_grant: got gnt=%b sel=%b%b cnt=%0d want gnt=0001 sel=00 cnt=1", gnt, sel1, sel2, burst_cnt);
    end
  endtask

  task automatic test_single();
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      tick(4'b0100);
      checks++;
      if (gnt !== 4'b0100 || {sel1, sel2} !== 2'b10 || busy !== 1'b1 ||
          burst_cnt !== CNT_W'((k % BURST_MAX) + 1)) begin
        errors++;
        $display("FAIL single_hold k=%0d: got gnt=%b sel=%b%b busy=%b cnt=%0d want gnt=0100 sel=10 busy=1 cnt=%0d",
                 k, gnt, sel1, sel2, busy, burst_cnt, (k % BURST_MAX) + 1);
      end
    end
    tick(4'b0000);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || {sel1, sel2} !== 2'b10 || burst_cnt !== CNT_W'(0)) begin
      errors++;
      $display("FAIL single_release: got gnt=%b busy=%b sel=%b%b cnt=%0d want gnt=0000 busy=0 sel=10 cnt=0",
               gnt, busy, sel1, sel2, burst_cnt);
    end
  endtask

  task automatic test_contention();
    logic [3:0] want_gnt;
    int         slot;
    apply_reset();
    // Every fifth cycle is the turnaround gap; owners advance A, B, C, D, A.
    for (int k = 0; k < 21; k++) begin
      tick(4'b1111);
      slot     = k / (BURST_MAX + 1);
      want_gnt = (k % (BURST_MAX + 1) == BURST_MAX) ? 4'b0000 : 4'(1 << (slot % 4));
      checks++;
      if (gnt !== want_gnt || {sel1, sel2} !== 2'(slot % 4) || busy !== (want_gnt != 4'b0000)) begin
        errors++;
        $display("FAIL contention k=%0d: got gnt=%b sel=%b%b busy=%b want gnt=%b sel=%0d",
                 k, gnt, sel1, sel2, busy, want_gnt, slot % 4);
      end
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    tick(4'b0011);
    tick(4'b0011);
    tick(4'b0010);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || {sel1, sel2} !== 2'b00) begin
      errors++;
      $display("FAIL early_release_gap: got gnt=%b busy=%b sel=%b%b want gnt=0000 busy=0 sel=00", gnt, busy, sel1, sel2);
    end
    // A comes back during the gap but ptr has moved past it.
    tick(4'b0011);
    checks++;
    if (gnt !== 4'b0010 || {sel1, sel2} !== 2'b01 || burst_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL early_release_next: got gnt=%b sel=%b%b cnt=%0d want gnt=0010 sel=01 cnt=1", gnt, sel1, sel2, burst_cnt);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    tick(4'b1000);
    for (int k = 0; k < BURST_MAX - 1; k++) tick(4'b1001);
    checks++;
    if (gnt !== 4'b1000 || burst_cnt !== CNT_W'(BURST_MAX)) begin
      errors++;
      $display("FAIL wrap_hold: got gnt=%b cnt=%0d want gnt=1000 cnt=%0d", gnt, burst_cnt, BURST_MAX);
    end
    tick(4'b1001);
    checks++;
    if (gnt !== 4'b0000 || {sel1, sel2} !== 2'b11) begin
      errors++;
      $display("FAIL wrap_gap: got gnt=%b sel=%b%b want gnt=0000 sel=11", gnt, sel1, sel2);
    end
    tick(4'b1001);
    checks++;
    if (gnt !== 4'b0001 || {sel1, sel2} !== 2'b00) begin
      errors++;
      $display("FAIL wrap_next: got gnt=%b sel=%b%b want gnt=0001 sel=00", gnt, sel1, sel2);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int k = 0; k < BURST_MAX; k++) tick(4'b1111);
    // A drops on the very edge its burst is exhausted.
    tick(4'b1110);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || burst_cnt !== CNT_W'(0)) begin
      errors++;
      $display("FAIL simultaneous_gap: got gnt=%b busy=%b cnt=%0d want gnt=0000 busy=0 cnt=0", gnt, busy, burst_cnt);
    end
    tick(4'b1110);
    checks++;
    if (gnt !== 4'b0010 || {sel1, sel2} !== 2'b01) begin
      errors++;
      $display("FAIL simultaneous_next: got gnt=%b sel=%b%b want gnt=0010 sel=01", gnt, sel1, sel2);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    apply_reset();
    r = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      // Requests are levels: each bit toggles with probability 1/4.
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3, 0) == 0) r[b] = ~r[b];
      tick(r);
      checks++;
      if (gnt !== exp_gnt || {sel1, sel2} !== exp_sel || busy !== exp_busy || burst_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL random k=%0d req=%b: got gnt=%b sel=%b%b busy=%b cnt=%0d want gnt=%b sel=%b busy=%b cnt=%0d",
                 k, r, gnt, sel1, sel2, busy, burst_cnt, exp_gnt, exp_sel, exp_busy, exp_cnt);
      end
      checks++;
      if (busy !== (|gnt) || int'(burst_cnt) > BURST_MAX) begin
        errors++;
        $display("FAIL random_invariant k=%0d: got busy=%b gnt=%b cnt=%0d want busy=|gnt cnt<=%0d",
                 k, busy, gnt, burst_cnt, BURST_MAX);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_wrap();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4x1 multiplexer datapath (inputs A, B, C, D; selects sel1, sel2) between four requesters. It grants one requester at a time and drives the mux select lines to match. It enforces a bounded burst length per grant and inserts a one-cycle turnaround gap between owners. It sits directly in front of the mux4x1 instance and replaces hand-driven select stimulus.

## Interface
- BURST_MAX, 4, maximum consecutive cycles one owner may hold the grant while others wait (legal range 1..7)
- CNT_W, 3, width of burst counter; must hold BURST_MAX
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  4  request vector; bit0 = A, bit1 = B, bit2 = C, bit3 = D; level, held while access wanted
- gnt  out  4  one-hot grant, registered; all-zero when no owner
- sel1  out  1  mux select MSB, registered
- sel2  out  1  mux select LSB, registered; {sel1,sel2}: 00 = A, 01 = B, 10 = C, 11 = D
- busy  out  1  high while any gnt bit is high
- burst_cnt  out  CNT_W  cycles the current owner has held gnt, 0 when idle

## Operation
- State machine, three states: IDLE, GRANT, GAP. Internal: owner (2 bits), ptr (2 bits, round-robin start), cnt.
- Arbitration pick: first set bit of req searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE: if req != 0 -> GRANT; owner = pick; gnt = onehot(pick); {sel1,sel2} = pick; cnt = 1. Else stay.
- GRANT:
  - req[owner] == 0 -> GAP.
  - cnt == BURST_MAX and (req & ~gnt) != 0 -> GAP (forced rotation).
  - cnt == BURST_MAX and no other request -> stay; cnt reloads to 1 (new burst).
  - otherwise stay; cnt = cnt + 1.
- GAP (exactly one cycle): gnt = 0, busy = 0, cnt = 0; ptr = owner + 1 (mod 4, 3 wraps to 0). Next: if req != 0 -> GRANT with pick from the updated ptr, same actions as IDLE; else -> IDLE.
- sel1/sel2 hold the last owner's value in IDLE and GAP; they change only on entry to GRANT.
- Fairness: with all four requesting continuously, grants cycle A, B, C, D, A, ...
- Requests from non-owners during GRANT do not affect gnt until the exit condition triggers.

## Timing
- Reset (asynchronous, immediate, any state): state = IDLE, gnt = 0000, sel1 = 0, sel2 = 0, busy = 0, burst_cnt = 0, ptr = 0, owner = 0.
- Grant latency: req sampled at edge N in IDLE -> gnt, sel, busy valid after edge N (one cycle).
- Release: owner drops req before edge N -> gnt = 0 after edge N; next grant after edge N+1 at earliest.
- Owner drop and burst expiry at the same edge: single GAP, identical to a plain drop.
- Owner re-raising req during GAP is arbitrated normally from the new ptr; it does not retain priority.
- BURST_MAX = 1: with contention, every grant lasts one cycle followed by a GAP.
- Reset mid-grant: gnt falls asynchronously. After reset release, the first pick starts from A (ptr = 0).
- busy == |gnt at all times. burst_cnt never exceeds BURST_MAX.

## Test plan
- Reset: rst_n low mid-grant with req = 1111 -> gnt = 0000, sel = 00, busy = 0, burst_cnt = 0 immediately. After release, first grant = 0001.
- Single requester: req = 0100 from IDLE -> next cycle gnt = 0100, sel1 = 1, sel2 = 0. Held for 10 cycles, burst_cnt counts 1..4 and repeats, no GAP. Drop req -> gnt = 0000 next cycle.
- Full contention, BURST_MAX = 4: req = 1111 -> gnt sequence 0001 x4, gap, 0010 x4, gap, 0100 x4, gap, 1000 x4, gap, 0001. sel follows 00, 01, 10, 11.
- Early release: req = 0011. A drops after 2 grant cycles -> GAP, then gnt = 0010, sel = 01. ptr has advanced past A.
- Wrap-around: D owns, req = 1001, D expires -> GAP, then gnt = 0001 (ptr wrapped 3 -> 0).
- Simultaneous events: owner drops req on the same edge its cnt reaches BURST_MAX with others pending -> exactly one GAP cycle, next owner chosen from ptr = owner + 1.
